spi_ip_sclk_gen: RTL and testbench
==================================

Name: spi_ip_sclk_gen

Overview:
Programmable SPI serial-clock generator for the master datapath. It supersedes the power-of-two divider: arbitrary integer half-period, CPOL/CPHA modes, and a bounded burst of N bits with a start/busy/done handshake. It drives the SCLK pin and gives the shift-register control sample and shift strobes. Configuration is latched at start, so software can rewrite the registers mid-transfer.

Parameters:
PARAM_DIV_WIDTH, 8, width of the half-period select; one SCLK half-period = half_period_i+1 system clocks.
PARAM_BITS_WIDTH, 5, width of the bit-count select; a burst is nbits_i+1 bits (1..2^PARAM_BITS_WIDTH).

Ports:
sclkg_clk_i  in  1  system clock; the only clock.
sclkg_rst_n_i  in  1  reset, asynchronous assert, active-low.
sclkg_start_i  in  1  one-cycle start request; ignored while busy.
sclkg_stop_i  in  1  abort the burst in progress.
sclkg_half_period_i  in  PARAM_DIV_WIDTH  half-period minus one.
sclkg_nbits_i  in  PARAM_BITS_WIDTH  bit count minus one.
sclkg_cpol_i  in  1  SCLK idle level.
sclkg_cpha_i  in  1  clock phase.
sclkg_sclk_o  out  1  registered serial clock.
sclkg_lead_o  out  1  strobe: SCLK leaves its idle level at the end of this cycle.
sclkg_trail_o  out  1  strobe: SCLK returns to its idle level at the end of this cycle.
sclkg_sample_o  out  1  strobe: capture MISO this cycle.
sclkg_shift_o  out  1  strobe: advance MOSI this cycle.
sclkg_busy_o  out  1  high when state is not IDLE.
sclkg_done_o  out  1  one-cycle burst-complete pulse.

Behaviour:
- Reset values: sclk_o=0, busy_o=0, state=IDLE, all counters=0, all latched config=0. All strobes are low while in reset.
- State IDLE:
  - sclk_o follows cpol_i, registered.
  - On start_i, latch half_period, nbits, cpol and cpha. Clear the prescaler and the edge counter. Go to RUN.
- State RUN:
  - The prescaler increments every cycle.
  - Terminal count is prescaler==hp_q; it is combinational, like a time base.
  - At terminal count: prescaler clears, sclk_o toggles, the edge counter increments.
  - Odd-numbered edges (1st, 3rd, ...) assert lead_o; even-numbered edges assert trail_o.
- Edge timing: the first edge strobe falls hp_q+1 cycles after the start cycle. Edges then repeat every hp_q+1 cycles.
- Burst length: exactly 2*(nbits_q+1) edges.
- Strobe mapping:
  - CPHA=0: sample_o=lead_o, shift_o=trail_o.
  - CPHA=1: shift_o=lead_o, sample_o=trail_o.
- Final edge: a trail edge. The next state is TAIL (feature on) or IDLE (feature off). SCLK ends at cpol_q.
- Stop: stop_i in RUN or TAIL wins over a same-cycle edge.
  - Next cycle: IDLE, sclk_o=cpol_q, no done_o.
  - Strobes are suppressed in the stop cycle.
- Start and stop together in IDLE: start wins, stop is ignored.
- start_i while busy: ignored, no queuing.
- hp_q=0: SCLK runs at clk/2 and a strobe fires every cycle.
- Width rules: the prescaler is PARAM_DIV_WIDTH bits. The edge counter is PARAM_BITS_WIDTH+1 bits and never wraps within a burst.
- Asynchronous reset mid-burst: immediately returns to reset values, with no done_o.

Optional Feature:
Macro SPI_IP_SCLK_GEN_GUARD_EN.
- Defined:
  - After the final edge, state TAIL counts a further hp_q+1 cycles with SCLK held at idle.
  - done_o=1 in the TAIL terminal-count cycle; the next state is IDLE.
  - This provides CS hold time.
- Undefined:
  - There is no TAIL state.
  - done_o is asserted in the same cycle as the final trail_o; the next state is IDLE.

Decomposition:
- Package spi_ip_sclk_gen_pkg holds:
  - the state encoding localparams IDLE/RUN/TAIL (2 bits);
  - the mode constants CPHA_LEAD_SAMPLE=0 and CPHA_LEAD_SHIFT=1.
- Sub-module spi_ip_sclk_prescaler:
  - contains the loadable half-period counter with enable and synchronous clear;
  - outputs a combinational terminal-count signal.

Test Plan:
- hp=1, nbits=7, cpol=0, cpha=0, start at cycle 0:
  - edges at cycles 2,4,...,32; lead at 2,6,...,30; sample=lead, shift=trail.
  - Without guard: done at 32, busy low at 33.
  - With guard: done at 34, busy low at 35.
- hp=0, nbits=0, cpol=1, cpha=1, start at cycle 0:
  - sclk 1→0 after cycle 1 (shift at 1), 0→1 after cycle 2 (sample at 2).
  - done at 2 without guard.
- hp=4 burst; stop_i asserted in the same cycle as the 3rd edge strobe:
  - no strobe in that cycle; next cycle IDLE, sclk=cpol, no done_o.
- Second start_i pulse mid-burst, and half_period_i/cpol_i changed mid-burst:
  - burst timing and polarity are unchanged, no restart, a single done_o.
- Asynchronous reset asserted mid-RUN, off the clock edge:
  - sclk_o=0 and busy_o=0 immediately; after reset release, a new start with nbits=3 produces exactly 8 edges.
- nbits=31 (maximum), hp=2:
  - exactly 64 edges at a 3-cycle spacing; edge counter does not wrap; exactly one done_o.

Source files
------------

// File: rtl/spi_ip_sclk_gen_pkg.sv
// Shared constants for the SPI serial-clock generator:
// FSM state encoding and CPHA mode values.
package spi_ip_sclk_gen_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;

    localparam logic CPHA_LEAD_SAMPLE = 1'b0;
    localparam logic CPHA_LEAD_SHIFT  = 1'b1;

endpackage

// File: rtl/spi_ip_sclk_prescaler.sv
// Half-period counter with enable and synchronous clear.
// Terminal count is combinational so edges line up with the count.
module spi_ip_sclk_prescaler #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] half_period,
    output logic                 tc
);

    logic [DIV_WIDTH-1:0] cnt;

    assign tc = (cnt == half_period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_ip_sclk_gen.sv
// SPI SCLK generator: burst of N bits, CPOL/CPHA, start/busy/done.
// SPI_IP_SCLK_GEN_GUARD_EN adds a TAIL half-period of CS hold before done.
module spi_ip_sclk_gen
    import spi_ip_sclk_gen_pkg::*;
#(
    parameter int PARAM_DIV_WIDTH  = 8,
    parameter int PARAM_BITS_WIDTH = 5
) (
    input  logic                        sclkg_clk_i,
    input  logic                        sclkg_rst_n_i,
    input  logic                        sclkg_start_i,
    input  logic                        sclkg_stop_i,
    input  logic [PARAM_DIV_WIDTH-1:0]  sclkg_half_period_i,
    input  logic [PARAM_BITS_WIDTH-1:0] sclkg_nbits_i,
    input  logic                        sclkg_cpol_i,
    input  logic                        sclkg_cpha_i,
    output logic                        sclkg_sclk_o,
    output logic                        sclkg_lead_o,
    output logic                        sclkg_trail_o,
    output logic                        sclkg_sample_o,
    output logic                        sclkg_shift_o,
    output logic                        sclkg_busy_o,
    output logic                        sclkg_done_o
);

    logic [1:0]                  state;
    logic [PARAM_DIV_WIDTH-1:0]  hp_q;
    logic [PARAM_BITS_WIDTH-1:0] nb_q;
    logic                        cpol_q;
    logic                        cpha_q;
    logic [PARAM_BITS_WIDTH:0]   ecnt;
    logic                        sclk;
    logic                        tc;
    logic                        edge_en;
    logic                        last;

    spi_ip_sclk_prescaler #(
        .DIV_WIDTH (PARAM_DIV_WIDTH)
    ) u_prescaler (
        .clk         (sclkg_clk_i),
        .rst_n       (sclkg_rst_n_i),
        .en          (state != IDLE),
        .clr         (state == IDLE),
        .half_period (hp_q),
        .tc          (tc)
    );

    // Stop wins over a coincident edge, so it gates every strobe.
    assign edge_en        = (state == RUN) && tc && !sclkg_stop_i;
    assign sclkg_lead_o   = edge_en && !ecnt[0];
    assign sclkg_trail_o  = edge_en && ecnt[0];
    // Final edge number is 2*(nbits+1), i.e. count 2*nbits+1 before increment.
    assign last           = sclkg_trail_o && (ecnt == {nb_q, 1'b1});
    assign sclkg_sample_o = (cpha_q == CPHA_LEAD_SAMPLE) ? sclkg_lead_o : sclkg_trail_o;
    assign sclkg_shift_o  = (cpha_q == CPHA_LEAD_SAMPLE) ? sclkg_trail_o : sclkg_lead_o;
    assign sclkg_busy_o   = (state != IDLE);
    assign sclkg_sclk_o   = sclk;

`ifdef SPI_IP_SCLK_GEN_GUARD_EN
    assign sclkg_done_o = (state == TAIL) && tc && !sclkg_stop_i;
`else
    assign sclkg_done_o = last;
`endif

    always_ff @(posedge sclkg_clk_i or negedge sclkg_rst_n_i) begin
        if (!sclkg_rst_n_i) begin
            state  <= IDLE;
            hp_q   <= '0;
            nb_q   <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            ecnt   <= '0;
            sclk   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk <= sclkg_cpol_i;
                    if (sclkg_start_i) begin
                        hp_q   <= sclkg_half_period_i;
                        nb_q   <= sclkg_nbits_i;
                        cpol_q <= sclkg_cpol_i;
                        cpha_q <= sclkg_cpha_i;
                        ecnt   <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (sclkg_stop_i) begin
                        sclk  <= cpol_q;
                        state <= IDLE;
                    end else if (tc) begin
                        sclk <= ~sclk;
                        ecnt <= ecnt + 1'b1;
                        if (last) begin
`ifdef SPI_IP_SCLK_GEN_GUARD_EN
                            state <= TAIL;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                TAIL: begin
                    sclk <= cpol_q;
                    if (sclkg_stop_i || tc) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ip_sclk_gen.sv
// Scoreboard bench for spi_ip_sclk_gen; expected strobe events are queued
// by the stimulus thread and popped by a monitor at each falling edge.
module tb_spi_ip_sclk_gen;

`ifdef SPI_IP_SCLK_GEN_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] hp_i;
    logic [4:0] nb_i;
    logic       cpol_i;
    logic       cpha_i;
    logic       sclk, lead, trail, sample, shift, busy, done;

    int cyc = 0;
    int ncmp = 0;
    int nerr = 0;
    int e_end;

    typedef struct {
        int         c;
        logic [5:0] f;
    } ev_t;
    ev_t q[$];

    spi_ip_sclk_gen dut (
        .sclkg_clk_i         (clk),
        .sclkg_rst_n_i       (rst_n),
        .sclkg_start_i       (start),
        .sclkg_stop_i        (stop),
        .sclkg_half_period_i (hp_i),
        .sclkg_nbits_i       (nb_i),
        .sclkg_cpol_i        (cpol_i),
        .sclkg_cpha_i        (cpha_i),
        .sclkg_sclk_o        (sclk),
        .sclkg_lead_o        (lead),
        .sclkg_trail_o       (trail),
        .sclkg_sample_o      (sample),
        .sclkg_shift_o       (shift),
        .sclkg_busy_o        (busy),
        .sclkg_done_o        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // flags: {lead, trail, sample, shift, done, sclk}
    always @(negedge clk) begin
        if (lead | trail | sample | shift | done) begin
            ev_t e;
            logic [5:0] a;
            a = {lead, trail, sample, shift, done, sclk};
            ncmp++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_event cyc=%0d flags=%b", cyc, a);
            end else begin
                e = q.pop_front();
                if (e.c != cyc || e.f != a) begin
                    nerr++;
                    $display("FAIL event got cyc=%0d flags=%b want cyc=%0d flags=%b",
                             cyc, a, e.c, e.f);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        int guard = 0;
        while (cyc < c && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic push(input int c, input logic [5:0] f);
        ev_t e;
        e.c = c;
        e.f = f;
        q.push_back(e);
    endtask

    // Expected edges of a burst started in cycle s; kmax limits how many.
    task automatic push_burst(input int s, input int hp, input int n,
                              input bit cp, input bit ph, input int kmax,
                              output int last_c);
        int total = 2 * (n + 1);
        last_c = s;
        for (int k = 1; k <= kmax; k++) begin
            bit ld = (k % 2) == 1;
            bit smp = ph ? !ld : ld;
            bit dn = !GUARD && (k == total);
            bit sc = ld ? cp : !cp;
            last_c = s + k * (hp + 1);
            push(last_c, {ld, !ld, smp, !smp, dn, sc});
        end
        if (GUARD && kmax == total) begin
            last_c = last_c + hp + 1;
            push(last_c, {4'b0000, 1'b1, cp});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        hp_i = '0;
        nb_i = '0;
        cpol_i = 1'b1;
        cpha_i = 1'b0;
        at_cycle(2);
        chk("rst_sclk", sclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {lead, trail, sample, shift, done}, 0);
        rst_n = 1'b1;
        at_cycle(4);
        cpol_i = 1'b0;

        // T1: hp=1 nbits=7 mode 0, with a mid-burst restart attempt
        push_burst(10, 1, 7, 1'b0, 1'b0, 16, e_end);
        at_cycle(10);
        hp_i = 8'd1; nb_i = 5'd7; start = 1'b1;
        at_cycle(11);
        start = 1'b0;
        at_cycle(20);
        start = 1'b1; hp_i = 8'd5; nb_i = 5'd0; cpol_i = 1'b1;
        at_cycle(21);
        start = 1'b0;
        chk("t1_end_cycle", e_end, GUARD ? 44 : 42);
        at_cycle(e_end);
        chk("t1_busy_last", busy, 1);
        at_cycle(e_end + 1);
        chk("t1_busy_after", busy, 0);
        at_cycle(55);
        chk("t1_drained", q.size(), 0);

        // T2: hp=0 nbits=0 cpol=1 cpha=1; stop with start in IDLE ignored
        cpha_i = 1'b1;
        push_burst(60, 0, 0, 1'b1, 1'b1, 2, e_end);
        at_cycle(60);
        hp_i = 8'd0; nb_i = 5'd0; start = 1'b1; stop = 1'b1;
        at_cycle(61);
        start = 1'b0; stop = 1'b0;
        at_cycle(e_end + 1);
        chk("t2_busy_after", busy, 0);
        chk("t2_sclk_idle", sclk, 1);
        at_cycle(75);
        chk("t2_drained", q.size(), 0);

        // T3: hp=4, stop on the third edge
        cpha_i = 1'b0;
        push_burst(80, 4, 3, 1'b1, 1'b0, 2, e_end);
        at_cycle(80);
        hp_i = 8'd4; nb_i = 5'd3; start = 1'b1;
        at_cycle(81);
        start = 1'b0;
        at_cycle(95);
        stop = 1'b1;
        at_cycle(96);
        stop = 1'b0;
        chk("t3_busy_after_stop", busy, 0);
        chk("t3_sclk_after_stop", sclk, 1);
        at_cycle(120);
        chk("t3_drained", q.size(), 0);

        // T5: async reset mid-RUN, then an 8-edge burst
        cpol_i = 1'b0;
        push_burst(130, 1, 7, 1'b0, 1'b0, 1, e_end);
        at_cycle(130);
        hp_i = 8'd1; nb_i = 5'd7; start = 1'b1;
        at_cycle(131);
        start = 1'b0;
        at_cycle(133);
        chk("t5_sclk_high", sclk, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_sclk", sclk, 0);
        chk("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_drained_rst", q.size(), 0);
        push_burst(140, 0, 3, 1'b0, 1'b0, 8, e_end);
        at_cycle(140);
        hp_i = 8'd0; nb_i = 5'd3; start = 1'b1;
        at_cycle(141);
        start = 1'b0;
        at_cycle(e_end + 1);
        chk("t5_busy_after", busy, 0);
        at_cycle(155);
        chk("t5_drained", q.size(), 0);

        // T6: nbits=31 hp=2 cpha=1, 64 edges
        cpha_i = 1'b1;
        push_burst(160, 2, 31, 1'b0, 1'b1, 64, e_end);
        at_cycle(160);
        hp_i = 8'd2; nb_i = 5'd31; start = 1'b1;
        at_cycle(161);
        start = 1'b0;
        chk("t6_end_cycle", e_end, GUARD ? 355 : 352);
        at_cycle(e_end);
        chk("t6_busy_last", busy, 1);
        at_cycle(e_end + 1);
        chk("t6_busy_after", busy, 0);
        at_cycle(400);
        chk("t6_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
